// File: rtl/fsk_byte_rx.sv
// Asynchronous-frame byte deframer fed by the FSK demodulator's bit strobe.
// Define PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fsk_byte_rx #(
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  // Abort on the edge where the inactivity counter would reach TIMEOUT-1.
  localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT - 2);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

  state_t               state, state_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic [CW-1:0]        bit_cnt, bit_cnt_nx;
  logic [TW-1:0]        idle_cnt, idle_cnt_nx;
  logic [DATA_BITS-1:0] data_out_nx;
  logic                 dv_nx, fe_nx, busy_nx;
  logic                 par_ok;

`ifdef PARITY_EN
  logic par_ok_nx, pe_nx;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // NOTE: every next-value gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    bit_cnt_nx  = bit_cnt;
    data_out_nx = data_out;
    dv_nx       = 1'b0;
    fe_nx       = 1'b0;
`ifdef PARITY_EN
    par_ok_nx   = par_ok;
    pe_nx       = 1'b0;
`endif
    idle_cnt_nx = (state == IDLE || bit_valid) ? '0 : idle_cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (bit_valid && !bit_in) begin
          bit_cnt_nx = '0;
          shift_nx   = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_nx   = {bit_in, shift[DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_valid) begin
          par_ok_nx = ~(^shift ^ bit_in);
          state_nx  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_valid) begin
          if (bit_in && par_ok) begin
            data_out_nx = shift;
            dv_nx       = 1'b1;
          end
          fe_nx    = ~bit_in;
`ifdef PARITY_EN
          pe_nx    = ~par_ok;
`endif
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A strobe in the timeout cycle is processed above and suppresses the abort.
    if (state != IDLE && !bit_valid && idle_cnt == TO_FIRE) begin
      fe_nx    = 1'b1;
      state_nx = IDLE;
    end

    busy_nx = (state_nx != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      shift      <= shift_nx;
      bit_cnt    <= bit_cnt_nx;
      idle_cnt   <= idle_cnt_nx;
      data_out   <= data_out_nx;
      data_valid <= dv_nx;
      frame_err  <= fe_nx;
      busy       <= busy_nx;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_ok     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_ok     <= par_ok_nx;
      parity_err <= pe_nx;
    end
  end
`endif

endmodule

// File: doc/fsk_byte_rx.md
# fsk_byte_rx

Byte deframer placed directly after the FSK zero-crossing demodulator. It consumes the demodulator's recovered bit and its one-cycle bit strobe, and hunts for an asynchronous start bit. It assembles DATA_BITS data bits LSB first, checks the stop bit (and parity when compiled in), and presents each good byte with a one-cycle valid pulse. A mid-frame inactivity timeout stops a stalled link from wedging the framer.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame, range 5..16.
- TIMEOUT, default 1024: clk cycles allowed between bit strobes inside a frame, minimum 2.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- bit_in  input  1  demodulated bit; sampled only when bit_valid=1.
- bit_valid  input  1  single-cycle strobe; each high cycle is one received bit.
- data_out  output  DATA_BITS  last accepted byte; holds until the next accepted byte.
- data_valid  output  1  one-cycle pulse; data_out is new in this cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout abort.
- parity_err  output  1  one-cycle pulse on a parity mismatch; constant 0 without PARITY_EN.
- busy  output  1  high while the state is not IDLE.

## Operation
- FSM states are IDLE, DATA, PARITY and STOP. All outputs are registered.
- IDLE:
  - A strobe with bit_in=0 is a start bit. It clears the bit counter, clears the shift register and goes to DATA.
  - A strobe with bit_in=1 is idle line and is ignored.
- DATA:
  - Each strobe shifts bit_in into the MSB of the shift register (shift right), which gives LSB-first order. It also increments the bit counter, which is $clog2(DATA_BITS+1) bits wide.
  - On the strobe carrying bit DATA_BITS-1, go to PARITY if PARITY_EN is defined, otherwise go to STOP.
- PARITY:
  - A strobe latches par_ok = (XOR of all data bits XOR bit_in) == 0, which is even parity. Then go to STOP.
- STOP:
  - A strobe with bit_in=1 and par_ok=1 loads data_out from the shift register and pulses data_valid.
  - bit_in=0 pulses frame_err.
  - par_ok=0 pulses parity_err. frame_err and parity_err may pulse in the same cycle.
  - data_valid pulses only when both checks pass.
  - After any STOP strobe, return to IDLE.
- Timeout:
  - The inactivity counter is $clog2(TIMEOUT) bits wide. It clears on every strobe and while in IDLE, and otherwise increments.
  - When it reaches TIMEOUT-1 outside IDLE: pulse frame_err, go to IDLE, leave data_out unchanged.
  - A strobe in the same cycle as the timeout wins: the bit is processed and the counter clears.
- An aborted or errored frame never modifies data_out.

## Timing
- Reset values:
  - State IDLE; shift register, counters and par_ok cleared.
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0.
- Latency: data_valid, frame_err and parity_err are high in the cycle after the clock edge that samples the stop-bit strobe.
- busy rises in the cycle after the start-bit strobe. It falls together with the result pulse.
- Back-to-back frames: a start-bit strobe in the cycle immediately after the STOP strobe is accepted.
- bit_valid held high for N cycles is N bits. The upstream contract is single-cycle strobes.
- rst mid-frame drops the partial frame immediately. No pulse is produced.

## Configuration
- PARITY_EN defined:
  - Frame is start, DATA_BITS data, one even-parity bit, stop.
  - The PARITY state and par_ok are present.
- PARITY_EN undefined:
  - Frame is start, DATA_BITS data, stop.
  - The PARITY state and par_ok logic are removed. par_ok is treated as 1 and parity_err is tied to 0.

## Test plan
- Good frame, no parity: strobes 0,1,0,1,0,0,1,0,1,1 (start, data 0xA5 LSB first, stop) -> data_out=0xA5, single data_valid pulse one cycle after the stop strobe, busy low afterwards.
- Bad stop bit: same sequence with stop bit 0 -> frame_err pulse, no data_valid, data_out keeps its previous value.
- Timeout: start plus 3 data strobes, then silence -> frame_err exactly TIMEOUT-1 cycles after the last strobe. The next start bit then decodes 0x3C correctly.
- PARITY_EN: 0x07 with parity bit 1 -> data_valid, data_out=0x07. 0x07 with parity bit 0 -> parity_err pulse, no data_valid.
- Back-to-back: 0x00 then 0xFF, with the second start strobe one cycle after the first stop strobe -> two data_valid pulses, values 0x00 then 0xFF.
- Reset mid-frame: rst after 4 data bits -> all outputs at reset values. The subsequent full frame 0x5A decodes correctly.
